// File: rtl/seq_pkg.sv
// Shared definitions for the sequence-detector front end.
// Holds the serializer state encoding, the bit-order constant and the
// helper that sizes the serializer bit counter.
package seq_pkg;

  // Serializer FSM states; PARITY is only reachable in parity builds.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

  // Words leave the serializer most-significant bit first.
  localparam bit SER_MSB_FIRST = 1'b1;

  // Width of a counter that must hold values 0..width.
  function automatic int ser_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_bit_serializer_if.sv
// Word-in / bit-out handshake bundle for seq_bit_serializer.
// master: the word producer (and observer of the serial stream).
// slave : the serializer itself.
interface seq_bit_serializer_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             x;
  logic             x_valid;
  logic             word_done;

  modport master (
    output in_valid, in_data,
    input  in_ready, x, x_valid, word_done
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, x, x_valid, word_done
  );

endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end for the sequence detectors.
// Accepts WIDTH-bit words on a valid/ready handshake and emits them one bit
// per clock on x, MSB first. A new word can be accepted on the last output
// cycle of the current one, so back-to-back words stream with no gap.
// Optional macro SER_PARITY_EN appends an even-parity bit after every word.
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_bit_serializer_if.slave bus
);

  localparam int CW = ser_cnt_w(WIDTH);

  ser_state_t       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
`ifdef SER_PARITY_EN
  logic             par;
`endif

  logic             last;
  logic             xfer;
  logic             out_bit;
  logic [WIDTH-1:0] shreg_next;

  // Pick the outgoing bit and the shifted register according to bit order.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    out_bit    = 1'b0;
    shreg_next = shreg;
    if (SER_MSB_FIRST) begin
      out_bit    = shreg[WIDTH-1];
      shreg_next = {shreg[WIDTH-2:0], 1'b0};
    end else begin
      out_bit    = shreg[0];
      shreg_next = {1'b0, shreg[WIDTH-1:1]};
    end
  end

  // Handshake and status decode, purely from registered state.
  always_comb begin
    last = 1'b0;
`ifdef SER_PARITY_EN
    last = (state == PARITY);
`else
    last = (state == SHIFT) && (cnt == '0);
`endif
    bus.in_ready  = (state == IDLE) || last;
    bus.word_done = last;
    xfer          = bus.in_valid && bus.in_ready;
  end

  // Serial output; forced low whenever no bit is being presented.
  always_comb begin
    bus.x       = 1'b0;
    bus.x_valid = 1'b0;
    case (state)
      SHIFT: begin
        bus.x       = out_bit;
        bus.x_valid = 1'b1;
      end
`ifdef SER_PARITY_EN
      PARITY: begin
        bus.x       = par;
        bus.x_valid = 1'b1;
      end
`endif
      default: begin
        bus.x       = 1'b0;
        bus.x_valid = 1'b0;
      end
    endcase
  end

  // FSM, shift register, bit counter and parity accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data registers are reset too; they are few, and it keeps x free of X right after reset.
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
`ifdef SER_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
      case (state)
        IDLE: begin
          if (xfer) begin
            shreg <= bus.in_data;
            cnt   <= CW'(WIDTH - 1);
`ifdef SER_PARITY_EN
            par   <= ^bus.in_data;
`endif
            state <= SHIFT;
          end
        end

        SHIFT: begin
          shreg <= shreg_next;
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
`ifdef SER_PARITY_EN
            // Payload finished; the parity bit follows next cycle.
            state <= PARITY;
`else
            // Last payload bit is on x now; chain straight into the next word.
            if (xfer) begin
              shreg <= bus.in_data;
              cnt   <= CW'(WIDTH - 1);
              state <= SHIFT;
            end else begin
              state <= IDLE;
            end
`endif
          end
        end

`ifdef SER_PARITY_EN
        PARITY: begin
          if (xfer) begin
            shreg <= bus.in_data;
            cnt   <= CW'(WIDTH - 1);
            par   <= ^bus.in_data;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule
